instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/tpu_pkg.sv | 26 ++
 rtl/instr_mem.sv | 22 ++
 rtl/instr_fetch.sv | 107 ++++++++++
 tb/tb_instr_fetch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU instruction path: opcodes, fetch FSM states
// and the default program memory depth.
package tpu_pkg;

    localparam int IMEM_DEPTH_DEFAULT = 32;

    localparam logic [2:0] LOAD_ADDR   = 3'b001;
    localparam logic [2:0] LOAD_WEIGHT = 3'b010;
    localparam logic [2:0] LOAD_INPUTS = 3'b011;
    localparam logic [2:0] VALID       = 3'b100;
    localparam logic [2:0] STORE       = 3'b101;
    localparam logic [2:0] HALT        = 3'b111;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_FETCH = 3'd1,
        FS_ISSUE = 3'd2,
        FS_WAIT  = 3'd3,
        FS_DONE  = 3'd4
    } fetch_state_t;

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:13] == HALT;
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Single-port instruction store: synchronous write, registered 1-cycle read.
module instr_mem #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: walks the program memory from address 0, forwarding
// one instruction per two cycles until HALT or the last address.
module instr_fetch
    import tpu_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    localparam int PC_W      = $clog2(IMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            prog_we,
    input  logic [PC_W-1:0] prog_addr,
    input  logic [15:0]     prog_wdata,
    input  logic            start,
    input  logic            stall,
    output logic [15:0]     instruction,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            done
);

    localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(IMEM_DEPTH - 1);

    fetch_state_t    state;
    logic            end_reached;
    logic            mem_we;
    logic [PC_W-1:0] mem_addr;
    logic [15:0]     mem_rdata;

    assign busy = (state == FS_FETCH) || (state == FS_ISSUE) || (state == FS_WAIT);

    // The port is shared: program loads only get it while the fetcher is idle.
    assign mem_we   = prog_we && !busy && !reset;
    assign mem_addr = mem_we ? prog_addr : pc;

    instr_mem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (PC_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (prog_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FS_IDLE;
            pc          <= '0;
            instruction <= '0;
            done        <= 1'b0;
            end_reached <= 1'b0;
        end else begin
            instruction <= '0;
            case (state)
                FS_IDLE: begin
                    if (start) begin
                        state       <= FS_FETCH;
                        pc          <= '0;
                        end_reached <= 1'b0;
                    end
                end
                FS_FETCH: begin
                    state <= FS_ISSUE;
                end
                FS_ISSUE: begin
                    if (is_halt(mem_rdata)) begin
                        state <= FS_DONE;
                    end else begin
                        instruction <= mem_rdata;
                        // pc parks on the last address instead of wrapping.
                        if (pc == LAST_ADDR) begin
                            end_reached <= 1'b1;
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                        if (stall) begin
                            state <= FS_WAIT;
                        end else if (pc == LAST_ADDR) begin
                            state <= FS_DONE;
                        end else begin
                            state <= FS_FETCH;
                        end
                    end
                end
                FS_WAIT: begin
                    if (!stall) begin
                        state <= end_reached ? FS_DONE : FS_FETCH;
                    end
                end
                FS_DONE: begin
                    if (start) begin
                        done  <= 1'b0;
                        state <= FS_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= FS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: issued words are compared, as a stream,
// against the program prefix that precedes the first HALT.
module tb_instr_fetch;

    localparam int DEPTH = 32;
    localparam int PW    = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          prog_we = 1'b0;
    logic [PW-1:0] prog_addr = '0;
    logic [15:0]   prog_wdata = '0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic [15:0]   instruction;
    logic [PW-1:0] pc;
    logic          busy;
    logic          done;

    instr_fetch #(.IMEM_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata),
        .start       (start),
        .stall       (stall),
        .instruction (instruction),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] prog [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_all();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            prog_we    = 1'b1;
            prog_addr  = PW'(i);
            prog_wdata = prog[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:13] == 3'b111) w[15:13] = 3'($urandom_range(1, 6));
        if (w == 16'h0000) w = 16'h2000;
        return w;
    endfunction

    task automatic set_demo();
        logic [15:0] demo [6];
        demo = '{16'h2004, 16'h4000, 16'h6000, 16'h8000, 16'hA000, 16'hE000};
        for (int i = 0; i < DEPTH; i++) prog[i] = (i < 6) ? demo[i] : rand_word();
    endtask

    // Runs the loaded program once and compares the issued stream with the
    // expected one. stall_at >= 0 holds stall for three cycles from that point.
    task automatic run_check(input string tag, input int stall_pct, input int stall_at,
                             input bit poke, input int exp_done_cyc);
        logic [15:0] exp_q [$];
        logic [15:0] got_q [$];
        int          got_cyc [$];
        int          exp_pc;
        int          cyc;
        int          bad_gaps;
        int          want_gap;
        int          n;
        exp_pc = DEPTH - 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (prog[i][15:13] == 3'b111) begin
                exp_pc = i;
                break;
            end
            exp_q.push_back(prog[i]);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        chk({tag, "_busy_running"}, 32'(busy), 32'd1);
        while (!done && cyc < 400) begin
            stall = ((stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 3)) ||
                    ((stall_pct > 0) && ($urandom_range(99) < stall_pct));
            if (poke) begin
                prog_we    = (cyc == 1);
                prog_addr  = PW'(1);
                prog_wdata = 16'hFFFF;
            end
            @(negedge clk);
            cyc++;
            if (instruction != 16'h0000) begin
                got_q.push_back(instruction);
                got_cyc.push_back(cyc);
            end
        end
        stall   = 1'b0;
        prog_we = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        if (exp_done_cyc >= 0) chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done_cyc));
        chk({tag, "_issue_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        chk({tag, "_final_pc"}, 32'(pc), 32'(exp_pc));
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        if (got_q.size() > 0) chk({tag, "_first_latency"}, 32'(got_cyc[0]), 32'd2);
        if (stall_pct == 0 && got_q.size() > 1) begin
            bad_gaps = 0;
            for (int i = 1; i < got_q.size(); i++) begin
                want_gap = (stall_at >= 0 && i == 2) ? 5 : 2;
                if (got_cyc[i] - got_cyc[i-1] != want_gap) bad_gaps++;
            end
            chk({tag, "_issue_spacing"}, 32'(bad_gaps), 32'd0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_cleared"}, 32'(done), 32'd0);
        @(negedge clk);
        chk({tag, "_idle_no_relaunch"}, 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_instruction", 32'(instruction), 32'd0);
        chk("reset_pc", 32'(pc), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        reset = 1'b0;

        set_demo();
        load_all();
        run_check("demo", 0, -1, 1'b0, 13);
        run_check("stall3", 0, 3, 1'b0, -1);
        run_check("busy_write", 0, -1, 1'b1, -1);

        // Reset in the cycle after the first ISSUE, then rerun the same program.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrun_first_word", 32'(instruction), 32'h2004);
        reset = 1'b1;
        @(negedge clk);
        chk("midrun_rst_instruction", 32'(instruction), 32'd0);
        chk("midrun_rst_busy", 32'(busy), 32'd0);
        chk("midrun_rst_pc", 32'(pc), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrun_no_partial", 32'(instruction), 32'd0);

        // Reset wins over start and prog_we asserted in the same cycle.
        reset      = 1'b1;
        start      = 1'b1;
        prog_we    = 1'b1;
        prog_addr  = '0;
        prog_wdata = 16'hE000;
        @(negedge clk);
        reset   = 1'b0;
        start   = 1'b0;
        prog_we = 1'b0;
        chk("rst_prio_busy", 32'(busy), 32'd0);
        run_check("after_reset", 0, -1, 1'b0, 13);

        for (int i = 0; i < DEPTH; i++) prog[i] = rand_word();
        prog[0] = 16'hE000;
        load_all();
        run_check("halt0", 0, -1, 1'b0, 3);

        for (int i = 0; i < DEPTH; i++) prog[i] = 16'h8000;
        load_all();
        run_check("nohalt", 0, -1, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) prog[i] = rand_word();
            if ($urandom_range(1) == 1) prog[$urandom_range(DEPTH - 1)] = 16'hE000 | 16'($urandom_range(16'h1FFF));
            load_all();
            run_check($sformatf("rand%0d", r), 30, -1, 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
